// File: rtl/trng_pkg.sv
// Shared types and constants for the TRNG request scheduler.
// Consumer-side FSM states and the default random word width.
package trng_pkg;

  localparam int TRNG_DATA_W = 8;

  typedef enum logic [1:0] {
    IDLE,
    WARMUP,
    RUN
  } sched_state_e;

endpackage

// File: rtl/trng_byte_fifo.sv
// Synchronous word FIFO with flush; head word is presented combinationally.
// Pointers carry an extra MSB so full and empty are distinguishable.
module trng_byte_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 8
) (
  input  logic                     clk,
  input  logic                     rstn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [DATA_W-1:0]        wdata,
  output logic [DATA_W-1:0]        rdata,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]       wr_ptr_q, wr_ptr_d;
  logic [AW:0]       rd_ptr_q, rd_ptr_d;
  logic [DATA_W-1:0] mem_q [DEPTH];

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !flush) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q[AW-1:0]];
  assign level = wr_ptr_q - rd_ptr_q;
  assign full  = (level == (AW+1)'(DEPTH));
  assign empty = (level == '0);

endmodule

// File: rtl/trng_req_scheduler.sv
// Gates the sampling unit, drops warm-up bytes, buffers good bytes and
// hands them out one per grant under round-robin arbitration.
module trng_req_scheduler
  import trng_pkg::*;
#(
  parameter int DATA_W       = TRNG_DATA_W,
  parameter int NUM_REQ      = 4,
  parameter int DEPTH        = 8,
  parameter int WARMUP_BYTES = 4
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   enable,
  input  logic [DATA_W-1:0]      rnd_in,
  input  logic                   rnd_valid,
  output logic                   src_run,
  input  logic [NUM_REQ-1:0]     req,
  output logic [NUM_REQ-1:0]     gnt,
  output logic [DATA_W-1:0]      rnd_data,
  output logic                   rnd_data_valid,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic                   warmup_done,
  output logic                   overflow
);

  localparam int CW = (WARMUP_BYTES > 0) ? $clog2(WARMUP_BYTES+1) : 1;
  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam logic [CW-1:0] WARM_MAX = CW'(WARMUP_BYTES);

  sched_state_e      state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic [PW-1:0]     rr_q, rr_d;
  logic [NUM_REQ-1:0] gnt_q, gnt_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              dv_q, dv_d;

  logic              push, pop, flush, active, found;
  logic [PW-1:0]     idx, pick;
  logic [DATA_W-1:0] f_rdata;
  logic              f_full, f_empty;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    rr_d    = rr_q;
    gnt_d   = '0;
    dv_d    = 1'b0;
    data_d  = data_q;
    push    = 1'b0;
    pop     = 1'b0;
    flush   = 1'b0;
    found   = 1'b0;
    idx     = '0;
    pick    = '0;
    active  = enable && (state_q != IDLE);

    for (int i = 0; i < NUM_REQ; i++) begin
      idx = PW'((int'(rr_q) + i) % NUM_REQ);
      if (!found && req[idx]) begin
        found = 1'b1;
        pick  = idx;
      end
    end

    // Arbitration uses the registered level, so a byte pushed this
    // cycle into an empty FIFO cannot be granted until next cycle.
    if (active && !f_empty && found) begin
      pop         = 1'b1;
      gnt_d[pick] = 1'b1;
      data_d      = f_rdata;
      dv_d        = 1'b1;
      rr_d        = PW'((int'(pick) + 1) % NUM_REQ);
    end

    if (active && state_q == RUN && rnd_valid) begin
      if (!f_full || pop) push  = 1'b1;
      else                ovf_d = 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (enable) state_d = (WARMUP_BYTES > 0) ? WARMUP : RUN;
      end
      WARMUP: begin
        if (rnd_valid) begin
          if (cnt_q != WARM_MAX) cnt_d = cnt_q + CW'(1);
          if (cnt_d == WARM_MAX) state_d = RUN;
        end
      end
      RUN: ;
      default: state_d = IDLE;
    endcase

    if (!enable || state_q == IDLE) begin
      flush = 1'b1;
      cnt_d = '0;
      ovf_d = 1'b0;
    end
    if (!enable) state_d = IDLE;
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      rr_q    <= '0;
      gnt_q   <= '0;
      data_q  <= '0;
      dv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      data_q  <= data_d;
      dv_q    <= dv_d;
    end
  end

  trng_byte_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (rnd_in),
    .rdata (f_rdata),
    .level (fifo_level),
    .full  (f_full),
    .empty (f_empty)
  );

  assign src_run        = (state_q != IDLE) && !f_full;
  assign warmup_done    = (state_q == RUN);
  assign overflow       = ovf_q;
  assign gnt            = gnt_q;
  assign rnd_data       = data_q;
  assign rnd_data_valid = dv_q;

endmodule

// File: tb/tb_trng_req_scheduler.sv
// Randomized and directed bench for trng_req_scheduler against a
// queue-based reference model of the scheduling rules.
module tb_trng_req_scheduler;

  localparam int DW    = 8;
  localparam int NREQ  = 4;
  localparam int DEPTH = 8;
  localparam int WARM  = 4;
  localparam int M_IDLE = 0;
  localparam int M_WARM = 1;
  localparam int M_RUN  = 2;

  logic          clk = 1'b0;
  logic          rstn = 1'b0;
  logic          enable = 1'b0;
  logic [DW-1:0] rnd_in = '0;
  logic          rnd_valid = 1'b0;
  logic          src_run;
  logic [NREQ-1:0] req = '0;
  logic [NREQ-1:0] gnt;
  logic [DW-1:0] rnd_data;
  logic          rnd_data_valid;
  logic [$clog2(DEPTH):0] fifo_level;
  logic          warmup_done;
  logic          overflow;

  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  logic [DW-1:0]   mq[$];
  int              mst, mwarm, mrr;
  logic            movf, mvalid;
  logic [NREQ-1:0] mgnt;
  logic [DW-1:0]   mdata;

  always #5 clk = ~clk;

  trng_req_scheduler #(
    .DATA_W(DW), .NUM_REQ(NREQ), .DEPTH(DEPTH), .WARMUP_BYTES(WARM)
  ) dut (
    .clk(clk), .rstn(rstn), .enable(enable), .rnd_in(rnd_in),
    .rnd_valid(rnd_valid), .src_run(src_run), .req(req), .gnt(gnt),
    .rnd_data(rnd_data), .rnd_data_valid(rnd_data_valid),
    .fifo_level(fifo_level), .warmup_done(warmup_done), .overflow(overflow)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    mst = M_IDLE; mwarm = 0; mrr = 0;
    movf = 1'b0; mvalid = 1'b0; mgnt = '0; mdata = '0;
  endtask

  task automatic model_step(input logic en, input logic v,
                            input logic [DW-1:0] d, input logic [NREQ-1:0] rq);
    int k;
    bit hit;
    hit = 0; k = 0;
    mgnt = '0; mvalid = 1'b0;
    if (en && mst != M_IDLE && mq.size() > 0) begin
      for (int i = 0; i < NREQ; i++)
        if (!hit && rq[(mrr + i) % NREQ]) begin
          hit = 1; k = (mrr + i) % NREQ;
        end
      if (hit) begin
        mgnt[k] = 1'b1;
        mdata = mq.pop_front();
        mvalid = 1'b1;
        mrr = (k + 1) % NREQ;
      end
    end
    if (en && mst == M_RUN && v) begin
      if (mq.size() < DEPTH) mq.push_back(d);
      else movf = 1'b1;
    end
    if (!en) begin
      mq.delete(); mwarm = 0; movf = 1'b0; mst = M_IDLE;
    end else if (mst == M_IDLE) begin
      mst = (WARM > 0) ? M_WARM : M_RUN;
    end else if (mst == M_WARM && v) begin
      mwarm++;
      if (mwarm >= WARM) mst = M_RUN;
    end
  endtask

  task automatic compare_all();
    chk("gnt", 32'(gnt), 32'(mgnt));
    chk("dvalid", 32'(rnd_data_valid), 32'(mvalid));
    chk("rdata", 32'(rnd_data), 32'(mdata));
    chk("level", 32'(fifo_level), 32'(mq.size()));
    chk("wdone", 32'(warmup_done), 32'(mst == M_RUN));
    chk("ovf", 32'(overflow), 32'(movf));
    chk("src_run", 32'(src_run), 32'(mst != M_IDLE && mq.size() != DEPTH));
  endtask

  task automatic step(input logic en, input logic v,
                      input logic [DW-1:0] d, input logic [NREQ-1:0] rq);
    enable = en; rnd_valid = v; rnd_in = d; req = rq;
    @(posedge clk);
    model_step(en, v, d, rq);
    #1;
    compare_all();
  endtask

  task automatic do_reset();
    rstn = 1'b0;
    enable = 1'b0; rnd_valid = 1'b0; rnd_in = '0; req = '0;
    model_reset();
    #1;
    compare_all();
    @(negedge clk);
    rstn = 1'b1;
  endtask

  task automatic bringup();
    do_reset();
    step(1'b1, 1'b0, '0, '0);
    for (int i = 0; i < WARM; i++) step(1'b1, 1'b1, 8'($urandom), '0);
  endtask

  task automatic push_bytes(input int n, input logic [DW-1:0] base);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1, base + 8'(i), '0);
  endtask

  initial begin
    logic [NREQ-1:0] eg, rq_hold;
    logic en_r, v_r;
    int rate;

    // 1: warm-up discards the first four strobes
    do_reset();
    step(1'b1, 1'b0, '0, '0);
    step(1'b1, 1'b1, 8'h11, '0);
    step(1'b1, 1'b1, 8'h22, '0);
    step(1'b1, 1'b1, 8'h33, '0);
    chk("t1_wdone_pre", 32'(warmup_done), 32'd0);
    step(1'b1, 1'b1, 8'h44, '0);
    chk("t1_wdone", 32'(warmup_done), 32'd1);
    chk("t1_level0", 32'(fifo_level), 32'd0);
    step(1'b1, 1'b1, 8'hA5, '0);
    chk("t1_level", 32'(fifo_level), 32'd1);

    // 2: round-robin drain of 0x01..0x04
    bringup();
    push_bytes(4, 8'h01);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, 1'b0, '0, 4'b1111);
      eg = 4'(1 << i);
      chk("t2_gnt", 32'(gnt), 32'(eg));
      chk("t2_data", 32'(rnd_data), 32'(i + 1));
    end
    step(1'b1, 1'b0, '0, '0);
    chk("t2_level", 32'(fifo_level), 32'd0);

    // 3: fill to full, then overflow
    push_bytes(DEPTH, 8'h40);
    chk("t3_level", 32'(fifo_level), 32'(DEPTH));
    chk("t3_src_run", 32'(src_run), 32'd0);
    step(1'b1, 1'b1, 8'hDD, '0);
    chk("t3_ovf", 32'(overflow), 32'd1);
    chk("t3_level2", 32'(fifo_level), 32'(DEPTH));

    // 4: push and pop together while full
    bringup();
    push_bytes(DEPTH, 8'h80);
    step(1'b1, 1'b1, 8'hEE, 4'b0100);
    chk("t4_gnt", 32'(gnt), 32'b0100);
    chk("t4_level", 32'(fifo_level), 32'(DEPTH));
    chk("t4_ovf", 32'(overflow), 32'd0);
    for (int i = 0; i < DEPTH; i++) step(1'b1, 1'b0, '0, 4'b1111);
    chk("t4_last", 32'(rnd_data), 32'hEE);

    // 5: enable drop wins over a pending grant
    bringup();
    push_bytes(5, 8'h60);
    step(1'b0, 1'b0, '0, 4'b1111);
    chk("t5_gnt", 32'(gnt), 32'd0);
    chk("t5_level", 32'(fifo_level), 32'd0);
    chk("t5_src_run", 32'(src_run), 32'd0);
    chk("t5_ovf", 32'(overflow), 32'd0);

    // 6: asynchronous reset during a grant cycle
    bringup();
    push_bytes(2, 8'h70);
    step(1'b1, 1'b0, '0, 4'b0001);
    chk("t6_gnt_pre", 32'(gnt), 32'b0001);
    #2 rstn = 1'b0;
    #1;
    chk("t6_gnt", 32'(gnt), 32'd0);
    chk("t6_dvalid", 32'(rnd_data_valid), 32'd0);
    chk("t6_level", 32'(fifo_level), 32'd0);
    model_reset();

    // random traffic with protocol-following requesters
    do_reset();
    rq_hold = '0;
    for (int c = 0; c < 4000; c++) begin
      rate = ((c / 500) % 2 == 0) ? 30 : 80;
      en_r = ($urandom_range(0, 99) < 98);
      v_r  = ($urandom_range(0, 99) < rate);
      rq_hold = rq_hold & ~mgnt;
      if ($urandom_range(0, 99) < 20) rq_hold = rq_hold | 4'($urandom);
      step(en_r, v_r, 8'($urandom), rq_hold);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
